gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_test_pkg.sv | 28 ++
 rtl/gate_truth_checker_if.sv | 32 +++
 rtl/and_gate.sv | 16 +
 rtl/gate_truth_checker_settle_counter.sv | 33 +++
 rtl/gate_truth_checker.sv | 121 ++++++++++++
 tb/tb_gate_truth_checker.sv | 150 +++++++++++++++
 6 files changed

// File: rtl/gate_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_test_pkg
// Brief    : Shared FSM state type, vector count and 2-input gate truth tables.
// Revision : 1.0
// ============================================================================
package gate_test_pkg;

    localparam int NUM_VECTORS = 4;

    // Bit i of a truth table is the expected y for vector index i = {a,b}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gate_truth_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_truth_checker_if
// Brief    : Control, gate-drive and result signals of the truth checker.
// Revision : 1.0
// ============================================================================
interface gate_truth_checker_if;

    logic       start;
    logic [3:0] truth_table;
    logic       y_dut;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_idx;
    logic       fail_seen;

    modport master (
        output start, truth_table, y_dut,
        input  a_out, b_out, busy, done, pass, err_count, first_fail_idx, fail_seen
    );

    modport slave (
        input  start, truth_table, y_dut,
        output a_out, b_out, busy, done, pass, err_count, first_fail_idx, fail_seen
    );

endinterface
`default_nettype wire

// File: rtl/and_gate.sv
`default_nettype none
// ============================================================================
// Module   : and_gate
// Brief    : Combinational 2-input AND gate.
// Revision : 1.0
// ============================================================================
module and_gate (
    input  wire logic i_a,
    input  wire logic i_b,
    output logic      o_y
);

    assign o_y = i_a & i_b;

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : settle_counter
// Brief    : Loadable down-counter with a zero flag; stops at zero.
// Revision : 1.0
// ============================================================================
module settle_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_dec,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_truth_checker
// Brief    : Sweeps {a,b} over 00..11 and checks an external gate's y output
//            against a latched 4-bit truth table.
// Revision : 1.0
// ============================================================================
module gate_truth_checker
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    gate_truth_checker_if.slave bus
);

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] C_LAST_IDX    = 2'(NUM_VECTORS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_idx;
    logic [3:0] r_tt;
    logic [2:0] r_err;
    logic [1:0] r_ffi;
    logic       r_fail;
    logic       r_pass;
    logic       r_a;
    logic       r_b;
    logic       w_load;
    logic       w_dec;
    logic       w_cnt_zero;
    logic       w_mismatch;
    logic [2:0] w_err_next;

    settle_counter #(
        .WIDTH (4)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (C_SETTLE_LOAD),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE:    if (bus.start) w_next = DRIVE;
            DRIVE: begin
                w_load = 1'b1;
                w_next = SETTLE;
            end
            SETTLE: begin
                if (w_cnt_zero) w_next = SAMPLE;
                else            w_dec  = 1'b1;
            end
            SAMPLE:  w_next = (r_idx == C_LAST_IDX) ? DONE : DRIVE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_mismatch = (r_state == SAMPLE) && (bus.y_dut != r_tt[r_idx]);
    assign w_err_next = (w_mismatch && (r_err != 3'd4)) ? r_err + 3'd1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_tt    <= 4'd0;
            r_err   <= 3'd0;
            r_ffi   <= 2'd0;
            r_fail  <= 1'b0;
            r_pass  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_tt   <= bus.truth_table;
                        r_err  <= 3'd0;
                        r_ffi  <= 2'd0;
                        r_fail <= 1'b0;
                        r_pass <= 1'b0;
                        r_idx  <= 2'd0;
                    end
                end
                DRIVE: {r_a, r_b} <= r_idx;
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch) begin
                        if (!r_fail) r_ffi <= r_idx;
                        r_fail <= 1'b1;
                    end
                    // pass is registered here so it is already valid while done is high.
                    if (r_idx == C_LAST_IDX) r_pass <= (w_err_next == 3'd0);
                    else                     r_idx  <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.a_out          = r_a;
    assign bus.b_out          = r_b;
    assign bus.busy           = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
    assign bus.done           = (r_state == DONE);
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err;
    assign bus.first_fail_idx = r_ffi;
    assign bus.fail_seen      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_truth_checker
// Brief    : Directed bench for gate_truth_checker driving an and_gate.
// Revision : 1.0
// ============================================================================
module tb_gate_truth_checker;
    import gate_test_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       stuck;
    logic [3:0] tt_r;
    logic       y_and1;
    logic       y_and2;
    logic [1:0] ab_hist [0:63];
    logic [10:0] obs1;
    logic [10:0] obs2;
    int         checks   = 0;
    int         failures = 0;
    int         lat;
    int         ndone;

    always #5 clk = ~clk;

    gate_truth_checker_if bus1 ();
    gate_truth_checker_if bus2 ();

    and_gate u_and1 (.i_a(bus1.a_out), .i_b(bus1.b_out), .o_y(y_and1));
    and_gate u_and2 (.i_a(bus2.a_out), .i_b(bus2.b_out), .o_y(y_and2));

    assign bus1.y_dut       = stuck ? 1'b0 : y_and1;
    assign bus2.y_dut       = y_and2;
    assign bus1.truth_table = tt_r;
    assign bus2.truth_table = tt_r;

    gate_truth_checker #(.SETTLE_CYCLES(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    gate_truth_checker #(.SETTLE_CYCLES(5)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign obs1 = {bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass,
                   bus1.err_count, bus1.first_fail_idx, bus1.fail_seen};
    assign obs2 = {bus2.a_out, bus2.b_out, bus2.busy, bus2.done, bus2.pass,
                   bus2.err_count, bus2.first_fail_idx, bus2.fail_seen};

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Cycle 0 is the cycle start is high; cycle c is sampled on the negedge after edge c-1.
    task automatic sweep(input bit sel, input logic [3:0] tt, input int rst_at,
                         input int s1, input int s2, output int o_lat, output int o_ndone);
        o_lat   = 0;
        o_ndone = 0;
        @(negedge clk);
        tt_r = tt;
        if (sel) bus2.start = 1'b1; else bus1.start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            bus1.start = !sel && ((c == s1) || (c == s2));
            bus2.start =  sel && ((c == s1) || (c == s2));
            rst        = (c == rst_at);
            if (c == 5) tt_r = ~tt;
            if (sel ? bus2.done : bus1.done) begin
                o_ndone++;
                if (o_lat == 0) o_lat = c;
            end
            ab_hist[c] = sel ? obs2[10:9] : obs1[10:9];
            if ((rst_at > 0) && (c == rst_at + 1))
                chk("reset_mid_sweep_outputs", sel ? obs2 : obs1, 0);
        end
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        stuck      = 1'b0;
        tt_r       = 4'd0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_dut1", obs1, 0);
        chk("reset_outputs_dut2", obs2, 0);
        rst = 1'b0;

        // Scenario 1: AND table on an AND gate
        sweep(1'b0, TT_AND, 0, 0, 0, lat, ndone);
        chk("s1_latency", lat, 17);
        chk("s1_done_count", ndone, 1);
        chk("s1_pass", bus1.pass, 1);
        chk("s1_err_count", bus1.err_count, 0);
        chk("s1_fail_seen", bus1.fail_seen, 0);

        // Scenario 2: OR table mismatches at indices 1 and 2
        sweep(1'b0, TT_OR, 0, 0, 0, lat, ndone);
        chk("s2_latency", lat, 17);
        chk("s2_pass", bus1.pass, 0);
        chk("s2_err_count", bus1.err_count, 2);
        chk("s2_first_fail_idx", bus1.first_fail_idx, 1);
        chk("s2_fail_seen", bus1.fail_seen, 1);

        // Scenario 3: y stuck at 0, only index 3 mismatches
        stuck = 1'b1;
        sweep(1'b0, TT_AND, 0, 0, 0, lat, ndone);
        stuck = 1'b0;
        chk("s3_err_count", bus1.err_count, 1);
        chk("s3_first_fail_idx", bus1.first_fail_idx, 3);
        chk("s3_pass", bus1.pass, 0);
        chk("s3_ab_before_drive", ab_hist[1], 2'b11);
        for (int c = 2; c <= 17; c++) chk($sformatf("s3_ab_cycle%0d", c), ab_hist[c], (c - 2) / 4);
        chk("s3_ab_hold_after", ab_hist[40], 2'b11);

        // Scenario 4: starts while busy are ignored
        sweep(1'b0, TT_AND, 0, 3, 8, lat, ndone);
        chk("s4_latency", lat, 17);
        chk("s4_done_count", ndone, 1);
        chk("s4_pass", bus1.pass, 1);

        // Scenario 5: reset during SETTLE of vector 2, then a clean sweep
        sweep(1'b0, TT_AND, 10, 0, 0, lat, ndone);
        chk("s5_no_done_after_reset", ndone, 0);
        chk("s5_idle_outputs", obs1, 0);
        sweep(1'b0, TT_AND, 0, 0, 0, lat, ndone);
        chk("s5_restart_latency", lat, 17);
        chk("s5_restart_pass", bus1.pass, 1);

        // XOR table: indices 1,2,3 mismatch
        sweep(1'b0, TT_XOR, 0, 0, 0, lat, ndone);
        chk("xor_err_count", bus1.err_count, 3);
        chk("xor_first_fail_idx", bus1.first_fail_idx, 1);
        chk("xor_pass", bus1.pass, 0);

        // Scenario 6: SETTLE_CYCLES = 5
        sweep(1'b1, TT_AND, 0, 0, 0, lat, ndone);
        chk("s6_latency", lat, 29);
        chk("s6_done_count", ndone, 1);
        chk("s6_pass", bus2.pass, 1);
        chk("s6_err_count", bus2.err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
